// File: rtl/axistream_forwarder.sv
// Drains an accepted packet buffer through the forwarder read port into an AXI-Stream master.
// Optional define FWD_TKEEP_EN: the final beat carries a partial TKEEP derived from the length.
module axistream_forwarder #(
  parameter int unsigned SN_FWD_DATA_WIDTH = 64,
  parameter int unsigned SN_FWD_ADDR_WIDTH = 9,
  parameter int unsigned PLEN_WIDTH        = 32,
  parameter int unsigned BRAM_LAT          = 2,
  localparam int unsigned KEEP_WIDTH       = SN_FWD_DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy_for_fwd,
  output logic                         rdy_for_fwd_ack,
  input  logic [PLEN_WIDTH-1:0]        fwd_byte_len,
  output logic [SN_FWD_ADDR_WIDTH-1:0] fwd_addr,
  output logic                         fwd_rd_en,
  input  logic [SN_FWD_DATA_WIDTH-1:0] fwd_rd_data,
  output logic                         fwd_done,
  output logic [SN_FWD_DATA_WIDTH-1:0] fwd_TDATA,
  output logic [KEEP_WIDTH-1:0]        fwd_TKEEP,
  output logic                         fwd_TVALID,
  output logic                         fwd_TLAST,
  input  logic                         fwd_TREADY
);
  localparam int unsigned Depth = BRAM_LAT + 2;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam logic [PLEN_WIDTH-1:0] MaxWords = PLEN_WIDTH'(1) << SN_FWD_ADDR_WIDTH;
  localparam logic [PLEN_WIDTH-1:0] KeepW    = PLEN_WIDTH'(KEEP_WIDTH);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                       state_q, state_d;
  logic [SN_FWD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SN_FWD_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [PLEN_WIDTH-1:0]        len_words, len_rem;
  logic                         len_clamped;

  logic [BRAM_LAT-1:0]          pipe_vld_q, pipe_last_q;
  logic [CntW-1:0]              inflight;
  logic                         credit_ok;

  logic [SN_FWD_DATA_WIDTH-1:0] fifo_data_q [Depth];
  logic [Depth-1:0]             fifo_last_q;
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]              fifo_cnt_q;
  logic                         push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Word count rounds up; lengths beyond the buffer are clamped to a full buffer.
  always_comb begin
    len_rem     = fwd_byte_len % KeepW;
    len_words   = fwd_byte_len / KeepW + ((len_rem != '0) ? PLEN_WIDTH'(1) : '0);
    len_clamped = len_words > MaxWords;
    last_addr_d = len_clamped ? '1 : SN_FWD_ADDR_WIDTH'(len_words - PLEN_WIDTH'(1));
  end

`ifdef FWD_TKEEP_EN
  logic [KEEP_WIDTH-1:0] last_keep_q, last_keep_d;
  logic [KEEP_WIDTH-1:0] fifo_keep_q [Depth];

  always_comb begin
    last_keep_d = '1;
    if (!len_clamped && (len_rem != '0)) begin
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
        last_keep_d[i] = PLEN_WIDTH'(i) < len_rem;
      end
    end
  end
`endif

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < BRAM_LAT; i++) begin
      inflight = inflight + CntW'(pipe_vld_q[i]);
    end
    // Every slot reserved by an outstanding read must still fit once it lands.
    credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, inflight}) < (CntW + 1)'(Depth);
  end

  assign push = pipe_vld_q[BRAM_LAT-1];
  assign pop  = fwd_TVALID & fwd_TREADY;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    fwd_rd_en       = 1'b0;
    rdy_for_fwd_ack = 1'b0;
    fwd_done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        addr_d          = '0;
        rdy_for_fwd_ack = rdy_for_fwd;
        if (rdy_for_fwd) begin
          state_d = (fwd_byte_len == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (credit_ok) begin
          fwd_rd_en = 1'b1;
          if (addr_q == last_addr_q) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (pop && fwd_TLAST) begin
          state_d = StDone;
        end
      end
      StDone: begin
        fwd_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      last_addr_q <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
`ifdef FWD_TKEEP_EN
      last_keep_q <= '1;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (rdy_for_fwd_ack) begin
        last_addr_q <= last_addr_d;
`ifdef FWD_TKEEP_EN
        last_keep_q <= last_keep_d;
`endif
      end
      pipe_vld_q[0]  <= fwd_rd_en;
      pipe_last_q[0] <= fwd_rd_en & (addr_q == last_addr_q);
      for (int unsigned i = 1; i < BRAM_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= fwd_rd_data;
      fifo_last_q[wr_ptr_q] <= pipe_last_q[BRAM_LAT-1];
`ifdef FWD_TKEEP_EN
      fifo_keep_q[wr_ptr_q] <= pipe_last_q[BRAM_LAT-1] ? last_keep_q : '1;
`endif
    end
  end

  assign fwd_addr   = addr_q;
  assign fwd_TVALID = fifo_cnt_q != '0;
  assign fwd_TDATA  = fwd_TVALID ? fifo_data_q[rd_ptr_q] : '0;
  assign fwd_TLAST  = fwd_TVALID & fifo_last_q[rd_ptr_q];
`ifdef FWD_TKEEP_EN
  assign fwd_TKEEP  = fwd_TVALID ? fifo_keep_q[rd_ptr_q] : '0;
`else
  assign fwd_TKEEP  = {KEEP_WIDTH{fwd_TVALID}};
`endif

endmodule

// File: doc/axistream_forwarder.md
# axistream_forwarder

Reads a finished packet out of a packet-memory buffer through the parallel_cores forwarder port and emits it as an AXI-Stream master, one word per beat, with TLAST on the final word. It is the transmit-side counterpart of the stream snooper: the snooper fills buffers, this block drains accepted ones. It absorbs BRAM read latency and downstream backpressure with a small credit-controlled output FIFO.

## Interface
- SN_FWD_DATA_WIDTH, 64: buffer word / TDATA width in bits; a multiple of 8.
- SN_FWD_ADDR_WIDTH, 9: buffer word-address width.
- PLEN_WIDTH, 32: width of the packet byte length.
- BRAM_LAT, 2: BRAM read latency in cycles; legal values are 1 and 2.
- KEEP_WIDTH, SN_FWD_DATA_WIDTH/8: derived; do not set.
- Clocking and reset: clk is the clock; rst is the reset, synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy_for_fwd  in  1  parallel_cores has a packet ready to forward
- rdy_for_fwd_ack  out  1  packet accepted this cycle
- fwd_byte_len  in  PLEN_WIDTH  packet length in bytes; sampled on ack
- fwd_addr  out  SN_FWD_ADDR_WIDTH  buffer read word address
- fwd_rd_en  out  1  read strobe
- fwd_rd_data  in  SN_FWD_DATA_WIDTH  read data, valid BRAM_LAT cycles after fwd_rd_en
- fwd_done  out  1  one-cycle pulse: packet fully sent, buffer may be freed
- fwd_TDATA  out  SN_FWD_DATA_WIDTH  stream data
- fwd_TKEEP  out  KEEP_WIDTH  byte enables
- fwd_TVALID  out  1  stream valid
- fwd_TLAST  out  1  last beat of packet
- fwd_TREADY  in  1  downstream ready

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - rdy_for_fwd_ack = rdy_for_fwd (combinational).
  - On ack: latch fwd_byte_len; compute words = ceil(len/KEEP_WIDTH) and clamp it to 2^SN_FWD_ADDR_WIDTH.
  - Compute last_keep:
    - Low (len mod KEEP_WIDTH) bits set.
    - All ones if the remainder is 0 or the length was clamped.
  - Go to READ, or to DONE if len = 0.
- READ:
  - Word address counter starts at 0.
  - Issue fwd_rd_en when (fifo_count + inflight) < DEPTH, with DEPTH = BRAM_LAT+2.
  - Address increments after each read.
  - After the read of word words-1, go to DRAIN.
- Returned data is pushed into the FIFO, tagged with last and keep. The last word gets last_keep; all others get all ones.
- DRAIN: on a beat with fwd_TVALID & fwd_TREADY & fwd_TLAST, go to DONE.
- DONE: fwd_done = 1 for exactly this cycle; next state is IDLE.
- fwd_TVALID = FIFO non-empty.
- TDATA, TKEEP and TLAST are taken from the FIFO head. They stay stable while TVALID=1 and TREADY=0.
- Pop on TVALID & TREADY.
- fwd_rd_en is 0 outside READ; fwd_addr returns to 0 in IDLE.

## Timing
- Reset values:
  - fwd_TVALID, fwd_TLAST, fwd_rd_en, fwd_done, rdy_for_fwd_ack: 0.
  - fwd_TDATA, fwd_TKEEP, fwd_addr: 0.
  - State: IDLE. FIFO and in-flight tags: empty.
- Ack in cycle T → first fwd_rd_en at T+1 → first fwd_TVALID at T+2+BRAM_LAT.
- Sustained throughput is 1 beat/cycle with TREADY held high.
- fwd_done fires in the cycle after the TLAST handshake.
- Zero length: fwd_done at T+1, and no beat is emitted.
- Minimum gap between packets: the next ack is possible in the first IDLE cycle after DONE.
- Backpressure: the credit rule keeps the FIFO from overflowing. Occupancy never exceeds DEPTH.
- Reset mid-packet:
  - Next cycle, TVALID=0 and the FIFO and in-flight tags are flushed.
  - No TLAST and no fwd_done are produced.
  - The next packet restarts at address 0.

## Configuration
- FWD_TKEEP_EN defined: the last beat carries last_keep as computed above.
- FWD_TKEEP_EN undefined: fwd_TKEEP is tied all ones and the last_keep logic is removed. Length still sets the beat count.

## Test plan
- len=24, W=64, TREADY=1: reads at addr 0,1,2; 3 consecutive beats, TKEEP 0xFF, TLAST on beat 3; fwd_done one cycle later.
- len=13 with FWD_TKEEP_EN: 2 beats; beat 2 TKEEP=0x1F with TLAST. Without the macro, beat 2 TKEEP=0xFF.
- len=0: ack at T, fwd_done at T+1, fwd_TVALID never asserted.
- len=64, TREADY toggling 1,0,1,0: 8 beats in order with no loss. TDATA stays stable while stalled, and the FIFO count stays ≤ BRAM_LAT+2.
- len=5000 with ADDR_WIDTH=9: clamped to 512 beats, last TKEEP=0xFF, addresses 0..511.
- rst asserted after 2 beats of a len=80 packet: TVALID=0 next cycle, no fwd_done. A following len=8 packet reads addr 0 and emits one beat with TLAST.
